// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - ARM-style decode stage: register file, decoder, condition check, ID/EX register
// Optional same-cycle writeback forwarding on register reads when ID_WB_BYPASS_EN is defined.
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       inst,
  input  logic [PC_W-1:0]   pc,
  input  logic              hazard,
  input  logic              freeze,
  input  logic              flush,
  input  logic [3:0]        sr,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [3:0]        ex_exe_cmd,
  output logic              ex_s,
  output logic              ex_b,
  output logic              ex_mem_w,
  output logic              ex_mem_r,
  output logic              ex_wb_en,
  output logic              ex_imm,
  output logic [11:0]       ex_shift_op,
  output logic [23:0]       ex_simm24,
  output logic [3:0]        ex_dest,
  output logic [3:0]        ex_src1,
  output logic [3:0]        ex_src2,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm
);

  logic [3:0]  f_cond;
  logic [1:0]  f_mode;
  logic        f_imm;
  logic [3:0]  f_opcode;
  logic        f_s;
  logic [3:0]  f_rn;
  logic [3:0]  f_rd;
  logic [3:0]  f_rm;

  assign f_cond   = inst[31:28];
  assign f_mode   = inst[27:26];
  assign f_imm    = inst[25];
  assign f_opcode = inst[24:21];
  assign f_s      = inst[20];
  assign f_rn     = inst[19:16];
  assign f_rd     = inst[15:12];
  assign f_rm     = inst[3:0];

  logic [3:0] dec_cmd;
  logic       dec_s;
  logic       dec_b;
  logic       dec_mem_w;
  logic       dec_mem_r;
  logic       dec_wb_en;

  always_comb begin
    dec_cmd   = 4'b0000;
    dec_s     = 1'b0;
    dec_b     = 1'b0;
    dec_mem_w = 1'b0;
    dec_mem_r = 1'b0;
    dec_wb_en = 1'b0;
    case (f_mode)
      2'b00: begin
        dec_s     = f_s;
        dec_wb_en = 1'b1;
        case (f_opcode)
          4'b1101: dec_cmd = 4'b0001;
          4'b1111: dec_cmd = 4'b1001;
          4'b0100: dec_cmd = 4'b0010;
          4'b0101: dec_cmd = 4'b0011;
          4'b0010: dec_cmd = 4'b0100;
          4'b0110: dec_cmd = 4'b0101;
          4'b0000: dec_cmd = 4'b0110;
          4'b1100: dec_cmd = 4'b0111;
          4'b0001: dec_cmd = 4'b1000;
          // compare-style ops only update flags
          4'b1010: begin
            dec_cmd   = 4'b0100;
            dec_wb_en = 1'b0;
            dec_s     = 1'b1;
          end
          4'b1000: begin
            dec_cmd   = 4'b0110;
            dec_wb_en = 1'b0;
            dec_s     = 1'b1;
          end
          default: begin
            dec_s     = 1'b0;
            dec_wb_en = 1'b0;
          end
        endcase
      end
      2'b01: begin
        if (f_opcode == 4'b0100) begin
          dec_cmd   = 4'b0010;
          dec_mem_r = f_s;
          dec_mem_w = ~f_s;
          dec_wb_en = f_s;
        end
      end
      2'b10: dec_b = 1'b1;
      default: ;
    endcase
  end

  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;
  logic cond_ok;

  assign {flag_n, flag_z, flag_c, flag_v} = sr;

  always_comb begin
    cond_ok = 1'b0;
    case (f_cond)
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = ~flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = ~flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = ~flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = ~flag_v;
      4'b1000: cond_ok = flag_c & ~flag_z;
      4'b1001: cond_ok = ~flag_c | flag_z;
      4'b1010: cond_ok = (flag_n == flag_v);
      4'b1011: cond_ok = (flag_n != flag_v);
      4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ok = flag_z | (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign src1    = f_rn;
  assign src2    = dec_mem_w ? f_rd : f_rm;
  assign two_src = ~f_imm | dec_mem_w;

  logic [DATA_W-1:0] rf [16];
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        rf[i] <= DATA_W'(i);
      end
    end else if (wb_en) begin
      rf[wb_dest] <= wb_value;
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign val_rn = (wb_en && (wb_dest == src1)) ? wb_value : rf[src1];
  assign val_rm = (wb_en && (wb_dest == src2)) ? wb_value : rf[src2];
`else
  assign val_rn = rf[src1];
  assign val_rm = rf[src2];
`endif

  logic bubble;

  assign bubble = flush | hazard | ~in_valid | ~cond_ok;

  // flush overrides freeze; a bubble still loads the data fields
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_exe_cmd  <= '0;
      ex_s        <= 1'b0;
      ex_b        <= 1'b0;
      ex_mem_w    <= 1'b0;
      ex_mem_r    <= 1'b0;
      ex_wb_en    <= 1'b0;
      ex_imm      <= 1'b0;
      ex_shift_op <= '0;
      ex_simm24   <= '0;
      ex_dest     <= '0;
      ex_src1     <= '0;
      ex_src2     <= '0;
      ex_val_rn   <= '0;
      ex_val_rm   <= '0;
    end else if (flush || !freeze) begin
      ex_pc       <= pc;
      ex_imm      <= f_imm;
      ex_shift_op <= inst[11:0];
      ex_simm24   <= inst[23:0];
      ex_dest     <= f_rd;
      ex_src1     <= src1;
      ex_src2     <= src2;
      ex_val_rn   <= val_rn;
      ex_val_rm   <= val_rm;
      if (bubble) begin
        ex_valid   <= 1'b0;
        ex_exe_cmd <= '0;
        ex_s       <= 1'b0;
        ex_b       <= 1'b0;
        ex_mem_w   <= 1'b0;
        ex_mem_r   <= 1'b0;
        ex_wb_en   <= 1'b0;
      end else begin
        ex_valid   <= 1'b1;
        ex_exe_cmd <= dec_cmd;
        ex_s       <= dec_s;
        ex_b       <= dec_b;
        ex_mem_w   <= dec_mem_w;
        ex_mem_r   <= dec_mem_r;
        ex_wb_en   <= dec_wb_en;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - table-driven scoreboard bench for id_stage_pipe
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        hazard;
  logic        freeze;
  logic        flush;
  logic [3:0]  sr;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [3:0]  ex_exe_cmd;
  logic        ex_s;
  logic        ex_b;
  logic        ex_mem_w;
  logic        ex_mem_r;
  logic        ex_wb_en;
  logic        ex_imm;
  logic [11:0] ex_shift_op;
  logic [23:0] ex_simm24;
  logic [3:0]  ex_dest;
  logic [3:0]  ex_src1;
  logic [3:0]  ex_src2;
  logic [31:0] ex_val_rn;
  logic [31:0] ex_val_rm;

  id_stage_pipe #(.DATA_W(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst), .pc(pc),
    .hazard(hazard), .freeze(freeze), .flush(flush), .sr(sr),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .src1(src1), .src2(src2), .two_src(two_src),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_exe_cmd(ex_exe_cmd), .ex_s(ex_s),
    .ex_b(ex_b), .ex_mem_w(ex_mem_w), .ex_mem_r(ex_mem_r), .ex_wb_en(ex_wb_en),
    .ex_imm(ex_imm), .ex_shift_op(ex_shift_op), .ex_simm24(ex_simm24),
    .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm)
  );

  always #5 clk = ~clk;

`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] BYP_RN = 32'h55;
`else
  localparam logic [31:0] BYP_RN = 32'h2;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  sr;
    logic        hz;
    logic        iv;
    logic [3:0]  e_src2;
    logic        e_two;
    logic        e_v;
    logic [3:0]  e_cmd;
    logic        e_s;
    logic        e_b;
    logic        e_mw;
    logic        e_mr;
    logic        e_wb;
    logic [3:0]  e_dest;
    logic [31:0] e_rn;
    logic [31:0] e_rm;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
    int          idx;
  } exp_t;

  vec_t tbl [20];
  exp_t exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [3:0] s, input logic h, input logic v);
    inst     = i;
    sr       = s;
    hazard   = h;
    in_valid = v;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ex_valid"},   64'(ex_valid),   64'h0);
    chk({tag, " ex_exe_cmd"}, 64'(ex_exe_cmd), 64'h0);
    chk({tag, " ex_wb_en"},   64'(ex_wb_en),   64'h0);
    chk({tag, " ex_b"},       64'(ex_b),       64'h0);
    chk({tag, " ex_pc"},      64'(ex_pc),      64'h0);
    chk({tag, " ex_dest"},    64'(ex_dest),    64'h0);
    chk({tag, " ex_val_rn"},  64'(ex_val_rn),  64'h0);
    chk({tag, " ex_simm24"},  64'(ex_simm24),  64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    //             inst          sr    hz    iv    src2  two   v     cmd   s     b     mw    mr    wb    dest  rn     rm
    tbl[0]  = '{32'hE0821003, 4'h0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'd2, 32'd3};
    tbl[1]  = '{32'hE4821000, 4'h0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'd2, 32'd1};
    tbl[2]  = '{32'h00821003, 4'h0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'd2, 32'd3};
    tbl[3]  = '{32'h00821003, 4'h4, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'd2, 32'd3};
    tbl[4]  = '{32'hE4953000, 4'h0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'd5, 32'd0};
    tbl[5]  = '{32'hE3510005, 4'h0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd1, 32'd5};
    tbl[6]  = '{32'hE1120003, 4'h0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd2, 32'd3};
    tbl[7]  = '{32'hE3E0400F, 4'h0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 32'd0, 32'd15};
    tbl[8]  = '{32'hE0621003, 4'h0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'd2, 32'd3};
    tbl[9]  = '{32'hE0821003, 4'h0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'd2, 32'd3};
    tbl[10] = '{32'hE0821003, 4'h0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'd2, 32'd3};
    tbl[11] = '{32'hF0821003, 4'hF, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'd2, 32'd3};
    tbl[12] = '{32'hA0821003, 4'h9, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'd2, 32'd3};
    tbl[13] = '{32'hB0821003, 4'h9, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'd2, 32'd3};
    tbl[14] = '{32'h80821003, 4'h2, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'd2, 32'd3};
    tbl[15] = '{32'h90821003, 4'h2, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'd2, 32'd3};
    tbl[16] = '{32'hEC000000, 4'h0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0};
    tbl[17] = '{32'hE0921003, 4'h0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'd2, 32'd3};
    tbl[18] = '{32'hEA000004, 4'h0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd4};
    tbl[19] = '{32'hE0221003, 4'h0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'd2, 32'd3};

    rst = 1'b1; freeze = 1'b0; flush = 1'b0; pc = 32'h0;
    wb_en = 1'b0; wb_dest = 4'h0; wb_value = 32'h0;
    drive(32'hE0821003, 4'h0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");

    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      exp_t e;
      @(negedge clk);
      drive(tbl[k].inst, tbl[k].sr, tbl[k].hz, tbl[k].iv);
      pc = 32'h1000 + 32'(k * 4);
      #1;
      chk($sformatf("v%0d src2", k),    64'(src2),    64'(tbl[k].e_src2));
      chk($sformatf("v%0d two_src", k), 64'(two_src), 64'(tbl[k].e_two));
      e.v = tbl[k]; e.pc = pc; e.idx = k;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("scoreboard underflow", 64'h1, 64'h0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk($sformatf("v%0d ex_valid", x.idx),   64'(ex_valid),   64'(x.v.e_v));
        chk($sformatf("v%0d ex_exe_cmd", x.idx), 64'(ex_exe_cmd), 64'(x.v.e_cmd));
        chk($sformatf("v%0d ex_s", x.idx),       64'(ex_s),       64'(x.v.e_s));
        chk($sformatf("v%0d ex_b", x.idx),       64'(ex_b),       64'(x.v.e_b));
        chk($sformatf("v%0d ex_mem_w", x.idx),   64'(ex_mem_w),   64'(x.v.e_mw));
        chk($sformatf("v%0d ex_mem_r", x.idx),   64'(ex_mem_r),   64'(x.v.e_mr));
        chk($sformatf("v%0d ex_wb_en", x.idx),   64'(ex_wb_en),   64'(x.v.e_wb));
        chk($sformatf("v%0d ex_dest", x.idx),    64'(ex_dest),    64'(x.v.e_dest));
        chk($sformatf("v%0d ex_val_rn", x.idx),  64'(ex_val_rn),  64'(x.v.e_rn));
        chk($sformatf("v%0d ex_val_rm", x.idx),  64'(ex_val_rm),  64'(x.v.e_rm));
        chk($sformatf("v%0d ex_src2", x.idx),    64'(ex_src2),    64'(x.v.e_src2));
        chk($sformatf("v%0d ex_pc", x.idx),      64'(ex_pc),      64'(x.pc));
      end
    end
    chk("scoreboard drained", 64'(exp_q.size()), 64'h0);

    // same-cycle writeback to a read register
    @(negedge clk);
    drive(32'hE0821003, 4'h0, 1'b0, 1'b1);
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h55;
    @(posedge clk); #1;
    chk("bypass ex_val_rn", 64'(ex_val_rn), 64'(BYP_RN));
    @(negedge clk);
    wb_en = 1'b0;
    @(posedge clk); #1;
    chk("stored ex_val_rn", 64'(ex_val_rn), 64'h55);

    // freeze holds outputs while writeback proceeds; flush beats freeze
    @(negedge clk);
    drive(32'hEA000004, 4'h0, 1'b0, 1'b1);
    pc = 32'h100;
    @(posedge clk); #1;
    chk("branch ex_b", 64'(ex_b), 64'h1);
    chk("branch ex_simm24", 64'(ex_simm24), 64'h4);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      freeze = 1'b1;
      drive(32'hE0821003, 4'h0, 1'b0, 1'b1);
      pc = 32'h200;
      wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h77;
      @(posedge clk); #1;
      chk($sformatf("freeze%0d ex_b", c),      64'(ex_b),      64'h1);
      chk($sformatf("freeze%0d ex_valid", c),  64'(ex_valid),  64'h1);
      chk($sformatf("freeze%0d ex_simm24", c), 64'(ex_simm24), 64'h4);
      chk($sformatf("freeze%0d ex_pc", c),     64'(ex_pc),     64'h100);
      chk($sformatf("freeze%0d ex_wb_en", c),  64'(ex_wb_en),  64'h0);
    end
    @(negedge clk);
    flush = 1'b1; wb_en = 1'b0;
    drive(32'hE0871003, 4'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("flush ex_valid",   64'(ex_valid),   64'h0);
    chk("flush ex_b",       64'(ex_b),       64'h0);
    chk("flush ex_wb_en",   64'(ex_wb_en),   64'h0);
    chk("flush ex_exe_cmd", 64'(ex_exe_cmd), 64'h0);
    chk("flush ex_dest",    64'(ex_dest),    64'h1);
    chk("flush ex_val_rn",  64'(ex_val_rn),  64'h77);

    // reset wins over freeze and writeback
    @(negedge clk);
    flush = 1'b0; freeze = 1'b0;
    drive(32'hE0821003, 4'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("pre-reset ex_valid", 64'(ex_valid), 64'h1);
    @(negedge clk);
    rst = 1'b1; freeze = 1'b1;
    wb_en = 1'b1; wb_dest = 4'd5; wb_value = 32'hAA;
    @(posedge clk); #1;
    chk_zero("rst+freeze");
    @(negedge clk);
    rst = 1'b0; freeze = 1'b0; wb_en = 1'b0;
    drive(32'hE0851002, 4'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("post-reset R5", 64'(ex_val_rn), 64'h5);
    chk("post-reset R2", 64'(ex_val_rm), 64'h2);
    chk("post-reset ex_valid", 64'(ex_valid), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
